// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: expands one LM/SM instruction into per-register
// micro-ops, lowest register first, at consecutive memory addresses.
module lmsm_sequencer #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int ADDR_INC = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    start,
  input  logic                    op,
  input  logic [DATA_W-1:0]       base_addr,
  input  logic [NREG-1:0]         reg_list,
  input  logic                    stage_ready,
  output logic                    seq_valid,
  output logic [$clog2(NREG)-1:0] seq_rf_addr,
  output logic [DATA_W-1:0]       seq_mem_addr,
  output logic                    seq_is_load,
  output logic                    seq_last,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = $clog2(NREG);
  localparam logic [DATA_W-1:0] INC = DATA_W'(ADDR_INC);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r;
  logic              op_r;
  logic [NREG-1:0]   mask_r;
  logic [DATA_W-1:0] addr_r;

  logic [NREG-1:0]   mask_next_s;
  logic [DATA_W-1:0] addr_next_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic              next_last_s;
  logic [IDX_W-1:0]  start_idx_s;
  logic              start_last_s;

  function automatic logic [IDX_W-1:0] low_idx(input logic [NREG-1:0] m);
    low_idx = {IDX_W{1'b0}};
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) low_idx = IDX_W'(i);
      else      low_idx = low_idx;
    end
  endfunction

  function automatic logic single_bit(input logic [NREG-1:0] m);
    single_bit = (m != {NREG{1'b0}}) && ((m & (m - NREG'(1))) == {NREG{1'b0}});
  endfunction

  // Next micro-op candidate once the current one is accepted, and the first one at start.
  always_comb begin
    mask_next_s  = mask_r & (mask_r - NREG'(1));
    addr_next_s  = addr_r + INC;
    next_idx_s   = low_idx(mask_next_s);
    next_last_s  = single_bit(mask_next_s);
    start_idx_s  = low_idx(reg_list);
    start_last_s = single_bit(reg_list);
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      op_r         <= 1'b0;
      mask_r       <= {NREG{1'b0}};
      addr_r       <= {DATA_W{1'b0}};
      seq_valid    <= 1'b0;
      seq_rf_addr  <= {IDX_W{1'b0}};
      seq_mem_addr <= {DATA_W{1'b0}};
      seq_is_load  <= 1'b0;
      seq_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else if (flush) begin
      state_r      <= IDLE;
      mask_r       <= {NREG{1'b0}};
      seq_valid    <= 1'b0;
      seq_rf_addr  <= {IDX_W{1'b0}};
      seq_mem_addr <= {DATA_W{1'b0}};
      seq_is_load  <= 1'b0;
      seq_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r   <= op;
            mask_r <= reg_list;
            addr_r <= base_addr;
            busy   <= 1'b1;
            if (reg_list != {NREG{1'b0}}) begin
              state_r      <= RUN;
              seq_valid    <= 1'b1;
              seq_rf_addr  <= start_idx_s;
              seq_mem_addr <= base_addr;
              seq_is_load  <= ~op;
              seq_last     <= start_last_s;
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stage_ready) begin
            mask_r <= mask_next_s;
            addr_r <= addr_next_s;
            if (seq_last) begin
              state_r      <= DONE;
              seq_valid    <= 1'b0;
              seq_rf_addr  <= {IDX_W{1'b0}};
              seq_mem_addr <= {DATA_W{1'b0}};
              seq_is_load  <= 1'b0;
              seq_last     <= 1'b0;
              done         <= 1'b1;
            end else begin
              seq_rf_addr  <= next_idx_s;
              seq_mem_addr <= addr_next_s;
              seq_is_load  <= ~op_r;
              seq_last     <= next_last_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          seq_valid <= 1'b0;
          seq_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: table of LM/SM sequences checked through
// an expected micro-op queue, plus hand-written flush and reset scenarios.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        start;
  logic        op;
  logic [15:0] base_addr;
  logic [7:0]  reg_list;
  logic        stage_ready;
  logic        seq_valid;
  logic [2:0]  seq_rf_addr;
  logic [15:0] seq_mem_addr;
  logic        seq_is_load;
  logic        seq_last;
  logic        busy;
  logic        done;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic [2:0]  rf;
    logic [15:0] mem;
    logic        load;
    logic        last;
  } uop_t;

  typedef struct {
    logic        op;
    logic [15:0] base;
    logic [7:0]  list;
    int          stalls;
    bit          poke;
    int          exp_cycles;
  } vec_t;

  uop_t exp_q[$];

  lmsm_sequencer #(.DATA_W(16), .NREG(8), .ADDR_INC(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
    .base_addr(base_addr), .reg_list(reg_list), .stage_ready(stage_ready),
    .seq_valid(seq_valid), .seq_rf_addr(seq_rf_addr), .seq_mem_addr(seq_mem_addr),
    .seq_is_load(seq_is_load), .seq_last(seq_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(seq_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
    chk({tag, "_load"},  32'(seq_is_load), 32'd0);
    chk({tag, "_last"},  32'(seq_last),  32'd0);
  endtask

  // Drive one instruction; expected micro-ops are queued from an independent bit walk.
  task automatic run_seq(input vec_t v);
    int n = $countones(v.list);
    int k = 0;
    int busy_cnt = 0;
    int done_cyc = -1;
    int stall_left = v.stalls;
    logic [15:0] a = v.base;
    uop_t u;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (v.list[i]) begin
        k++;
        u.rf = 3'(i); u.mem = a; u.load = ~v.op; u.last = (k == n);
        exp_q.push_back(u);
        a = a + 16'd1;
      end
    end
    start = 1'b1; op = v.op; base_addr = v.base; reg_list = v.list; stage_ready = 1'b1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        chk("done_no_valid", 32'(seq_valid), 32'd0);
      end
      if (seq_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_uop", 32'd1, 32'd0);
        end else begin
          chk("rf_addr",  32'(seq_rf_addr),  32'(exp_q[0].rf));
          chk("mem_addr", 32'(seq_mem_addr), 32'(exp_q[0].mem));
          chk("is_load",  32'(seq_is_load),  32'(exp_q[0].load));
          chk("last",     32'(seq_last),     32'(exp_q[0].last));
        end
      end else begin
        chk("load_outside_run", 32'(seq_is_load), 32'd0);
      end
      if (stall_left > 0) begin
        stage_ready = 1'b0;
        stall_left--;
      end else begin
        stage_ready = 1'b1;
      end
      if (stage_ready && seq_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (v.poke && c == 2) begin
        start = 1'b1; op = ~v.op; base_addr = 16'h0000; reg_list = 8'h02;
      end
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_cycles));
    chk("busy_cycles", 32'(busy_cnt), 32'(v.exp_cycles));
    chk("uops_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk_idle_outputs("after_done");
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{op: 1'b0, base: 16'h0010, list: 8'hA5, stalls: 0, poke: 1'b0, exp_cycles: 5};
    vecs[1] = '{op: 1'b1, base: 16'h1234, list: 8'h00, stalls: 0, poke: 1'b0, exp_cycles: 1};
    vecs[2] = '{op: 1'b1, base: 16'h0040, list: 8'h81, stalls: 3, poke: 1'b0, exp_cycles: 6};
    vecs[3] = '{op: 1'b0, base: 16'hFFFE, list: 8'h07, stalls: 0, poke: 1'b0, exp_cycles: 4};
    vecs[4] = '{op: 1'b1, base: 16'h0100, list: 8'hFF, stalls: 0, poke: 1'b1, exp_cycles: 9};
    vecs[5] = '{op: 1'b0, base: 16'h0003, list: 8'h80, stalls: 0, poke: 1'b0, exp_cycles: 2};

    reset = 1'b1; flush = 1'b0; start = 1'b0; op = 1'b0;
    base_addr = 16'h0000; reg_list = 8'h00; stage_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_rf", 32'(seq_rf_addr), 32'd0);
    chk("reset_mem", 32'(seq_mem_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) run_seq(vecs[t]);

    // Flush on the second micro-op of a full list, then a normal single-register start.
    start = 1'b1; op = 1'b0; base_addr = 16'h0020; reg_list = 8'hFF; stage_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("flush_pre_rf", 32'(seq_rf_addr), 32'd0);
    @(negedge clk);
    chk("flush_pre_rf2", 32'(seq_rf_addr), 32'd1);
    chk("flush_pre_mem2", 32'(seq_mem_addr), 32'h21);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk_idle_outputs("flush");
    @(negedge clk);
    chk_idle_outputs("flush_hold");
    run_seq('{op: 1'b0, base: 16'h0030, list: 8'h01, stalls: 0, poke: 1'b0, exp_cycles: 2});

    // Asynchronous reset in mid-RUN, then a start on the first edge after release.
    start = 1'b1; op = 1'b1; base_addr = 16'h0200; reg_list = 8'hFF; stage_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", 32'(seq_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_mem", 32'(seq_mem_addr), 32'd0);
    @(negedge clk);
    chk_idle_outputs("reset_held");
    reset = 1'b0;
    run_seq('{op: 1'b0, base: 16'h0050, list: 8'h02, stalls: 0, poke: 1'b0, exp_cycles: 2});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
